// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory between the instruction-cache (I) and data-cache (D)
//   controllers. A port that wins arbitration owns the memory for as long as
//   it holds req, so a write-back followed by a fill completes without the
//   other port interleaving. Ties are broken round-robin. Reads are tagged
//   with the issuing port and their data is steered back RD_LAT cycles later,
//   even if ownership has changed in the meantime.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   {i,d}_req                     request / hold ownership
//   {i,d}_rd, {i,d}_wr            access strobes (acted on only while owner)
//   {i,d}_addr, {i,d}_data_in     word address and write data
//   {i,d}_data_out, {i,d}_valid   returned read data (zero when not valid)
//   {i,d}_stall                   access presented this cycle was not taken
//   mem_addr, mem_data_in         memory address / write data (zero when unowned)
//   mem_rd, mem_wr                memory strobes
//   mem_data_out, mem_stall       memory read data / busy
//   err                           owner asserted rd and wr together
module mem_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data_in,
    output logic [15:0] i_data_out,
    output logic        i_valid,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    output logic [15:0] d_data_out,
    output logic        d_valid,
    output logic        d_stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_data_out,
    input  logic        mem_stall,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    // Port tag: 0 = I, 1 = D.
    localparam logic TAG_I = 1'b0;
    localparam logic TAG_D = 1'b1;

    state_t state, state_nxt;
    logic   last_grant;

    // Return pipeline: entry 0 is loaded on an accepted read, entry RD_LAT-1
    // lines up with mem_data_out.
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] tag_pipe;

    logic        own_i, own_d, own_any;
    logic        o_rd, o_wr;
    logic [15:0] o_addr, o_data;
    logic        push, tail_v, tail_tag;

    // ---------------- arbitration ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= TAG_I;
        end else begin
            state <= state_nxt;
            if (state_nxt == GRANT_I && state != GRANT_I) last_grant <= TAG_I;
            if (state_nxt == GRANT_D && state != GRANT_D) last_grant <= TAG_D;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req && d_req) state_nxt = (last_grant == TAG_I) ? GRANT_D : GRANT_I;
                else if (d_req)     state_nxt = GRANT_D;
                else if (i_req)     state_nxt = GRANT_I;
            end
            GRANT_I: if (!i_req) state_nxt = d_req ? GRANT_D : IDLE;
            GRANT_D: if (!d_req) state_nxt = i_req ? GRANT_I : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- owner mux / strobes ----------------
    // Everything is forced quiet while rst is high so the reset cycle itself
    // shows all-zero outputs.
    assign own_i   = (state == GRANT_I) & ~rst;
    assign own_d   = (state == GRANT_D) & ~rst;
    assign own_any = own_i | own_d;

    always_comb begin
        o_rd   = 1'b0;
        o_wr   = 1'b0;
        o_addr = '0;
        o_data = '0;
        if (own_i) begin
            o_rd = i_rd; o_wr = i_wr; o_addr = i_addr; o_data = i_data_in;
        end else if (own_d) begin
            o_rd = d_rd; o_wr = d_wr; o_addr = d_addr; o_data = d_data_in;
        end
    end

    assign mem_rd      = o_rd & ~o_wr;
    assign mem_wr      = o_wr & ~o_rd;
    assign mem_addr    = o_addr;
    assign mem_data_in = o_data;
    assign err         = own_any & o_rd & o_wr;

    // Owner stalls on memory busy or on an illegal rd+wr; a non-owner stalls
    // whenever it presents an access.
    always_comb begin
        i_stall = 1'b0;
        d_stall = 1'b0;
        if (!rst) begin
            if (own_i) i_stall = (mem_stall & (i_rd | i_wr)) | (i_rd & i_wr);
            else       i_stall = i_req & (i_rd | i_wr);
            if (own_d) d_stall = (mem_stall & (d_rd | d_wr)) | (d_rd & d_wr);
            else       d_stall = d_req & (d_rd | d_wr);
        end
    end

    // ---------------- read return ----------------
    assign push = mem_rd & ~mem_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= push;
            tag_pipe[0] <= own_d;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign tail_v   = vld_pipe[RD_LAT-1] & ~rst;
    assign tail_tag = tag_pipe[RD_LAT-1];

    assign i_valid    = tail_v & (tail_tag == TAG_I);
    assign d_valid    = tail_v & (tail_tag == TAG_D);
    assign i_data_out = i_valid ? mem_data_out : '0;
    assign d_data_out = d_valid ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_rd, i_wr;
    logic [15:0] i_addr, i_data_in, i_data_out;
    logic        i_valid, i_stall;
    logic        d_req, d_rd, d_wr;
    logic [15:0] d_addr, d_data_in, d_data_out;
    logic        d_valid, d_stall;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_rd, mem_wr, mem_stall, err;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_data_in(i_data_in),
        .i_data_out(i_data_out), .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .d_data_out(d_data_out), .d_valid(d_valid), .d_stall(d_stall),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out), .mem_stall(mem_stall), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_req = 0; i_rd = 0; i_wr = 0; i_addr = '0; i_data_in = '0;
        d_req = 0; d_rd = 0; d_wr = 0; d_addr = '0; d_data_in = '0;
        mem_data_out = '0; mem_stall = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; tick(); tick();
        rst = 0;
    endtask

    // Outputs all zero during and right after reset.
    task automatic test_reset();
        clear_inputs();
        rst = 1; tick();
        d_req = 1; d_rd = 1; d_addr = 16'h1111; mem_data_out = 16'hFFFF;
        settle();
        n_chk++; if ({i_valid, d_valid, i_stall, d_stall, mem_rd, mem_wr, err} !== 7'b0) begin n_fail++; $display("FAIL reset_in_rst: flags got %b want 0", {i_valid, d_valid, i_stall, d_stall, mem_rd, mem_wr, err}); end
        n_chk++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        tick(); clear_inputs(); rst = 0;
        settle();
        n_chk++; if ({i_valid, d_valid, i_stall, d_stall, mem_rd, mem_wr, err, i_data_out, d_data_out, mem_addr, mem_data_in} !== '0) begin n_fail++; $display("FAIL reset_after: outputs not all zero"); end
    endtask

    task automatic test_single_read();
        do_reset();
        d_req = 1; d_rd = 1; d_addr = 16'h1A28;
        settle();
        n_chk++; if (d_stall !== 1'b1) begin n_fail++; $display("FAIL sr_idle_stall: got %b want 1", d_stall); end
        n_chk++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL sr_idle_memrd: got %b want 0", mem_rd); end
        tick(); settle();
        n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 16'h1A28) begin n_fail++; $display("FAIL sr_issue: mem_rd %b addr %h want 1 1a28", mem_rd, mem_addr); end
        n_chk++; if (d_stall !== 1'b0) begin n_fail++; $display("FAIL sr_grant_stall: got %b want 0", d_stall); end
        tick(); d_rd = 0; settle();
        n_chk++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL sr_early_valid: got %b want 0", d_valid); end
        tick(); mem_data_out = 16'hBEEF; settle();
        n_chk++; if (d_valid !== 1'b1 || d_data_out !== 16'hBEEF) begin n_fail++; $display("FAIL sr_return: valid %b data %h want 1 beef", d_valid, d_data_out); end
        n_chk++; if (i_valid !== 1'b0 || i_data_out !== 16'h0) begin n_fail++; $display("FAIL sr_i_quiet: valid %b data %h want 0 0000", i_valid, i_data_out); end
        tick(); mem_data_out = '0; d_req = 0; settle();
        n_chk++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL sr_single_pulse: got %b want 0", d_valid); end
    endtask

    task automatic test_tie();
        do_reset();
        i_req = 1; d_req = 1; i_rd = 1; d_rd = 1; i_addr = 16'h1111; d_addr = 16'h2222;
        settle();
        n_chk++; if (i_stall !== 1'b1 || d_stall !== 1'b1) begin n_fail++; $display("FAIL tie_idle_stall: i %b d %b want 1 1", i_stall, d_stall); end
        tick(); settle();
        n_chk++; if (mem_addr !== 16'h2222 || d_stall !== 1'b0 || i_stall !== 1'b1) begin n_fail++; $display("FAIL tie_first_d: addr %h d_stall %b i_stall %b want 2222 0 1", mem_addr, d_stall, i_stall); end
        tick(); d_req = 0; d_rd = 0; settle();
        n_chk++; if (i_stall !== 1'b1 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL tie_d_last: i_stall %b mem_rd %b want 1 0", i_stall, mem_rd); end
        tick(); settle();
        n_chk++; if (mem_addr !== 16'h1111 || mem_rd !== 1'b1 || i_stall !== 1'b0) begin n_fail++; $display("FAIL tie_handover_i: addr %h rd %b stall %b want 1111 1 0", mem_addr, mem_rd, i_stall); end
        tick(); i_req = 0; i_rd = 0; settle();
        tick(); i_req = 1; d_req = 1; i_rd = 1; d_rd = 1; settle();
        n_chk++; if (mem_rd !== 1'b0 || d_stall !== 1'b1) begin n_fail++; $display("FAIL tie2_idle: mem_rd %b d_stall %b want 0 1", mem_rd, d_stall); end
        tick(); settle();
        n_chk++; if (mem_addr !== 16'h2222 || d_stall !== 1'b0) begin n_fail++; $display("FAIL tie2_d: addr %h d_stall %b want 2222 0", mem_addr, d_stall); end
        tick(); i_req = 0; d_req = 0; i_rd = 0; d_rd = 0; settle();
        tick(); i_req = 1; d_req = 1; i_rd = 1; d_rd = 1; settle();
        tick(); settle();
        n_chk++; if (mem_addr !== 16'h1111 || i_stall !== 1'b0 || d_stall !== 1'b1) begin n_fail++; $display("FAIL tie3_i: addr %h i_stall %b d_stall %b want 1111 0 1", mem_addr, i_stall, d_stall); end
        tick(); clear_inputs(); tick(); tick();
    endtask

    task automatic test_handover_inflight();
        do_reset();
        d_req = 1; tick();
        d_rd = 1; d_addr = 16'h0040; d_req = 0;
        i_req = 1; i_wr = 1; i_addr = 16'h0080; i_data_in = 16'h1234;
        settle();
        n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0040 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL ho_d_read: rd %b addr %h wr %b want 1 0040 0", mem_rd, mem_addr, mem_wr); end
        n_chk++; if (i_stall !== 1'b1) begin n_fail++; $display("FAIL ho_i_wait: got %b want 1", i_stall); end
        tick(); d_rd = 0; settle();
        n_chk++; if (mem_wr !== 1'b1 || mem_addr !== 16'h0080 || mem_data_in !== 16'h1234 || i_stall !== 1'b0) begin n_fail++; $display("FAIL ho_i_write: wr %b addr %h data %h stall %b want 1 0080 1234 0", mem_wr, mem_addr, mem_data_in, i_stall); end
        tick(); i_wr = 0; mem_data_out = 16'h5A5A; settle();
        n_chk++; if (d_valid !== 1'b1 || d_data_out !== 16'h5A5A) begin n_fail++; $display("FAIL ho_d_return: valid %b data %h want 1 5a5a", d_valid, d_data_out); end
        n_chk++; if (i_valid !== 1'b0 || i_data_out !== 16'h0) begin n_fail++; $display("FAIL ho_i_noreturn: valid %b data %h want 0 0000", i_valid, i_data_out); end
        tick(); clear_inputs(); tick();
    endtask

    task automatic test_mem_stall();
        int acc [4];
        int k = 0;
        int stalls = 0;
        int bad = 0;
        for (int j = 0; j < 4; j++) acc[j] = 0;
        do_reset();
        d_req = 1; tick();
        i_req = 1; i_rd = 1; i_addr = 16'h7777;
        for (int cyc = 0; cyc < 12 && k < 4; cyc++) begin
            d_wr = 1; d_addr = 16'h2000 + 16'(2 * k); d_data_in = 16'(k);
            mem_stall = (cyc >= 1 && cyc <= 3);
            settle();
            if (mem_wr !== 1'b1 || mem_addr !== 16'h2000 + 16'(2 * k) || d_stall !== mem_stall || i_stall !== 1'b1) bad++;
            if (d_stall === 1'b1) stalls++;
            if (mem_wr === 1'b1 && !mem_stall && mem_addr >= 16'h2000 && mem_addr <= 16'h2006) acc[(mem_addr - 16'h2000) >> 1]++;
            if (d_stall === 1'b0) k++;
            tick();
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL st_cycle: %0d bad cycles want 0", bad); end
        n_chk++; if (k != 4) begin n_fail++; $display("FAIL st_done: words %0d want 4", k); end
        n_chk++; if (stalls != 3) begin n_fail++; $display("FAIL st_count: stall cycles %0d want 3", stalls); end
        for (int j = 0; j < 4; j++) begin
            n_chk++; if (acc[j] != 1) begin n_fail++; $display("FAIL st_accept%0d: accepted %0d want 1", j, acc[j]); end
        end
        clear_inputs(); tick(); tick();
    endtask

    task automatic test_err();
        do_reset();
        i_req = 1; i_rd = 1; i_wr = 1; settle();
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_nonowner: got %b want 0", err); end
        i_req = 0; i_rd = 0; i_wr = 0;
        d_req = 1; tick();
        d_rd = 1; d_wr = 1; d_addr = 16'h0003; settle();
        n_chk++; if (err !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || d_stall !== 1'b1) begin n_fail++; $display("FAIL err_both: err %b rd %b wr %b stall %b want 1 0 0 1", err, mem_rd, mem_wr, d_stall); end
        tick(); d_wr = 0; settle();
        n_chk++; if (err !== 1'b0 || mem_rd !== 1'b1 || d_stall !== 1'b0) begin n_fail++; $display("FAIL err_clear: err %b rd %b stall %b want 0 1 0", err, mem_rd, d_stall); end
        tick(); clear_inputs(); tick(); tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        d_req = 1; tick();
        d_rd = 1; d_addr = 16'h0010; tick();
        d_addr = 16'h0012; tick();
        rst = 1; d_req = 0; d_rd = 0; mem_data_out = 16'hCAFE; settle();
        n_chk++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_in_rst: d_valid %b want 0", d_valid); end
        tick(); rst = 0; settle();
        n_chk++; if ({i_valid, d_valid, i_stall, d_stall, mem_rd, mem_wr, err, i_data_out, d_data_out, mem_addr, mem_data_in} !== '0) begin n_fail++; $display("FAIL rmb_after: outputs not all zero, d_valid %b d_data %h", d_valid, d_data_out); end
        tick(); d_req = 1; d_rd = 1; d_addr = 16'h0014; settle();
        n_chk++; if (d_stall !== 1'b1 || mem_rd !== 1'b0 || d_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_idle: stall %b rd %b valid %b want 1 0 0", d_stall, mem_rd, d_valid); end
        tick(); clear_inputs(); tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_single_read();
        test_tie();
        test_handover_inflight();
        test_mem_stall();
        test_err();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
